// File: rtl/mux_tree_pipe_if.sv
// rtl/mux_tree_pipe_if.sv - valid/ready request and result bundle for mux_tree_pipe
//
// Purpose: groups the request side (in_*) and result side (out_*) of the
// pipelined mux tree into one bundle.
// Signals:
//   in_valid/in_ready   request handshake
//   in_data             NUM_IN flattened words, word k = in_data[k*WIDTH +: WIDTH]
//   in_sel              index of the selected word
//   in_tag              opaque tag carried alongside the request
//   out_valid/out_ready result handshake
//   out_data/out_tag    selected word and its tag
//   out_err             set when the request's in_sel was >= NUM_IN
// Modports: slave = the mux tree, master = the requester/consumer side.

interface mux_tree_pipe_if #(
    parameter int WIDTH  = 64,
    parameter int NUM_IN = 32
);
    localparam int LEVELS = $clog2(NUM_IN);

    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [LEVELS-1:0]       in_sel;
    logic [7:0]              in_tag;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic [7:0]              out_tag;
    logic                    out_err;

    modport slave (
        input  in_valid, in_data, in_sel, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_err
    );

    modport master (
        output in_valid, in_data, in_sel, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_err
    );
endinterface

// File: rtl/mux_tree_pipe.sv
// rtl/mux_tree_pipe.sv - pipelined NUM_IN:1 binary mux tree with valid/ready stages
//
// Purpose: selects one of NUM_IN WIDTH-bit words through LEVELS = clog2(NUM_IN)
// levels of 2:1 selection, with a valid/ready pipeline register after every level.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset; clears every stage register
//   flush  synchronous; invalidates every stage on the next edge
//   bus    mux_tree_pipe_if.slave request/result bundle

module mux_tree_pipe #(
    parameter int WIDTH  = 64,
    parameter int NUM_IN = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    mux_tree_pipe_if.slave bus
);
    localparam int LEVELS = $clog2(NUM_IN);

    logic [LEVELS-1:0] r_valid;
    logic [LEVELS-1:0] w_load;
    logic [LEVELS-1:0] w_vin;
    logic              w_go;

    // Stage j loads when it is empty or stage j+1 loads. Unrolled from the
    // output back, that is: out_ready or any stage at/after j being empty.
    always_comb begin
        w_go   = bus.out_ready;
        w_load = '0;
        for (int j = LEVELS - 1; j >= 0; j--) begin
            w_go      = w_go | ~r_valid[j];
            w_load[j] = w_go;
        end
    end

    // Valid bit offered to each stage by its upstream neighbour.
    always_comb begin
        w_vin    = '0;
        w_vin[0] = bus.in_valid;
        for (int j = 1; j < LEVELS; j++) begin
            w_vin[j] = r_valid[j-1];
        end
    end

    // flush wins over any acceptance in the same cycle; data registers are
    // left alone because an invalid stage's contents are never observed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            r_valid <= (r_valid & ~w_load) | (w_vin & w_load);
        end
    end

    assign bus.in_ready  = w_load[0];
    assign bus.out_valid = r_valid[LEVELS-1];

    for (genvar j = 0; j < LEVELS; j++) begin : g_lvl
        // Surviving candidates after this level.
        localparam int NW = (NUM_IN + (1 << (j + 1)) - 1) >> (j + 1);

        logic [2*NW*WIDTH-1:0] w_cand;
        logic [NW*WIDTH-1:0]   w_pick;
        logic                  w_bit;
        logic [7:0]            w_tag;
        logic                  w_err;
        logic [NW*WIDTH-1:0]   r_flat;
        logic [7:0]            r_tag;
        logic                  r_err;

        // Candidates are zero-extended to an even count, so a missing leaf
        // (or a whole missing subtree) always reads as 0.
        if (j == 0) begin : g_src
            assign w_cand = (2*NW*WIDTH)'(bus.in_data);
            assign w_bit  = bus.in_sel[0];
            assign w_tag  = bus.in_tag;
            assign w_err  = (int'(bus.in_sel) >= NUM_IN);
        end else begin : g_src
            assign w_cand = (2*NW*WIDTH)'(g_lvl[j-1].r_flat);
            assign w_bit  = g_lvl[j-1].g_sel.r_sel[0];
            assign w_tag  = g_lvl[j-1].r_tag;
            assign w_err  = g_lvl[j-1].r_err;
        end

        // Remaining select bits travel with the data, shifted so that the
        // bit consumed by the next level is always at position 0.
        if (j < LEVELS - 1) begin : g_sel
            logic [LEVELS-j-2:0] r_sel;
            logic [LEVELS-j-2:0] w_sel_next;

            if (j == 0) begin : g_sel_src
                assign w_sel_next = bus.in_sel[LEVELS-1:1];
            end else begin : g_sel_src
                assign w_sel_next = g_lvl[j-1].g_sel.r_sel[LEVELS-j-1:1];
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_sel <= '0;
                end else if (w_load[j]) begin
                    r_sel <= w_sel_next;
                end
            end
        end

        always_comb begin
            w_pick = '0;
            for (int m = 0; m < NW; m++) begin
                w_pick[m*WIDTH +: WIDTH] = w_bit ? w_cand[(2*m+1)*WIDTH +: WIDTH]
                                                 : w_cand[2*m*WIDTH +: WIDTH];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_flat <= '0;
                r_tag  <= '0;
                r_err  <= 1'b0;
            end else if (w_load[j]) begin
                r_flat <= w_pick;
                r_tag  <= w_tag;
                r_err  <= w_err;
            end
        end
    end

    assign bus.out_data = g_lvl[LEVELS-1].r_flat;
    assign bus.out_tag  = g_lvl[LEVELS-1].r_tag;
    assign bus.out_err  = g_lvl[LEVELS-1].r_err;
endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb/tb_mux_tree_pipe.sv - self-checking bench for mux_tree_pipe (32:1, 5:1 and 2:1 instances)

module tb_mux_tree_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic flush32;
    logic flush5;
    logic flush2;

    mux_tree_pipe_if #(.WIDTH(64), .NUM_IN(32)) b32 ();
    mux_tree_pipe_if #(.WIDTH(16), .NUM_IN(5))  b5 ();
    mux_tree_pipe_if #(.WIDTH(1),  .NUM_IN(2))  b2 ();

    mux_tree_pipe #(.WIDTH(64), .NUM_IN(32)) u_dut32 (.clk(clk), .reset(reset), .flush(flush32), .bus(b32.slave));
    mux_tree_pipe #(.WIDTH(16), .NUM_IN(5))  u_dut5  (.clk(clk), .reset(reset), .flush(flush5),  .bus(b5.slave));
    mux_tree_pipe #(.WIDTH(1),  .NUM_IN(2))  u_dut2  (.clk(clk), .reset(reset), .flush(flush2),  .bus(b2.slave));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model for the 32:1 instance: a FIFO of expected results,
    // an occupancy count, and the output seen last cycle for hold checks.
    typedef struct {
        logic [63:0] data;
        logic [7:0]  tag;
        logic        err;
        int          acc_cyc;
    } exp_t;

    exp_t        q32[$];
    int          cyc = 0;
    int          occ32 = 0;
    int          delivered = 0;
    int          first_lat = -1;
    int          first_del_cyc = 0;
    int          last_del_cyc = 0;
    int          saw_full = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic [7:0]  prev_tag;
    logic        prev_err;

    function automatic logic [63:0] ref_word(input logic [32*64-1:0] d, input int sel);
        if (sel >= 32) return 64'd0;
        return d[sel*64 +: 64];
    endfunction

    task automatic cycle32(output logic acc_o);
        logic rdy;
        logic ov;
        logic acc;
        logic del;
        exp_t e;
        #2;
        rdy = b32.in_ready;
        ov  = b32.out_valid;
        acc = b32.in_valid && rdy && !flush32;
        del = ov && b32.out_ready;
        if (!rdy) saw_full++;
        chk("in_ready_vs_occupancy", rdy, (occ32 < 5) || b32.out_ready);
        if (occ32 == 0) chk("no_spurious_valid", ov, 1'b0);
        if (prev_stall) begin
            chk("hold_valid", ov, 1'b1);
            chk("hold_data", b32.out_data, prev_data);
            chk("hold_tag", b32.out_tag, prev_tag);
            chk("hold_err", b32.out_err, prev_err);
        end
        if (del && q32.size() > 0) begin
            e = q32.pop_front();
            chk("out_data", b32.out_data, e.data);
            chk("out_tag", b32.out_tag, e.tag);
            chk("out_err", b32.out_err, e.err);
            if (delivered == 0) begin
                first_lat     = cyc - e.acc_cyc;
                first_del_cyc = cyc;
            end
            last_del_cyc = cyc;
            delivered++;
        end
        if (acc) begin
            e.data    = ref_word(b32.in_data, int'(b32.in_sel));
            e.tag     = b32.in_tag;
            e.err     = 1'b0;
            e.acc_cyc = cyc;
            q32.push_back(e);
        end
        prev_stall = ov && !b32.out_ready;
        prev_data  = b32.out_data;
        prev_tag   = b32.out_tag;
        prev_err   = b32.out_err;
        step();
        cyc++;
        if (del) occ32--;
        if (acc) occ32++;
        if (flush32) begin
            q32.delete();
            occ32      = 0;
            prev_stall = 1'b0;
        end
        acc_o = acc;
    endtask

    task automatic load_sweep_words();
        for (int k = 0; k < 32; k++) b32.in_data[k*64 +: 64] = 64'hA5A5_0000_0000_0000 + 64'(k);
    endtask

    task automatic drain32();
        b32.in_valid  = 1'b0;
        b32.out_ready = 1'b1;
        for (int c = 0; c < 20 && occ32 > 0; c++) begin
            logic a;
            cycle32(a);
        end
        chk("drain_empty", 64'(q32.size()), 64'd0);
    endtask

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] data;
        logic        err;
    } v5_t;

    typedef struct {
        logic sel;
        logic d1;
        logic d0;
        logic exp;
    } v2_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        v5_t  t5[5];
        v2_t  t2[8];
        logic a;
        int   sent;

        t5[0] = '{3'd4, 16'h1104, 1'b0};
        t5[1] = '{3'd5, 16'h0000, 1'b1};
        t5[2] = '{3'd7, 16'h0000, 1'b1};
        t5[3] = '{3'd0, 16'h1100, 1'b0};
        t5[4] = '{3'd2, 16'h1102, 1'b0};

        t2[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        t2[1] = '{1'b0, 1'b0, 1'b1, 1'b1};
        t2[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
        t2[3] = '{1'b0, 1'b1, 1'b1, 1'b1};
        t2[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        t2[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
        t2[6] = '{1'b1, 1'b1, 1'b0, 1'b1};
        t2[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

        reset   = 1'b1;
        flush32 = 1'b0;
        flush5  = 1'b0;
        flush2  = 1'b0;
        b32.in_valid = 1'b0; b32.in_data = '0; b32.in_sel = '0; b32.in_tag = '0; b32.out_ready = 1'b1;
        b5.in_valid  = 1'b0; b5.in_data  = '0; b5.in_sel  = '0; b5.in_tag  = '0; b5.out_ready  = 1'b1;
        b2.in_valid  = 1'b0; b2.in_data  = '0; b2.in_sel  = '0; b2.in_tag  = '0; b2.out_ready  = 1'b1;

        step();
        step();
        #3 reset = 1'b0;
        #1;
        chk("rst32_out_valid", b32.out_valid, 1'b0);
        chk("rst32_out_data", b32.out_data, 64'd0);
        chk("rst32_out_tag", b32.out_tag, 8'd0);
        chk("rst32_out_err", b32.out_err, 1'b0);
        chk("rst32_in_ready", b32.in_ready, 1'b1);
        chk("rst5_out_valid", b5.out_valid, 1'b0);
        chk("rst5_in_ready", b5.in_ready, 1'b1);
        chk("rst2_out_valid", b2.out_valid, 1'b0);
        chk("rst2_out_data", b2.out_data, 1'b0);
        step();

        // Ordering sweep: sel 0..31 back-to-back, tag = sel.
        load_sweep_words();
        b32.out_ready = 1'b1;
        delivered = 0;
        sent = 0;
        for (int c = 0; c < 80 && delivered < 32; c++) begin
            b32.in_valid = (sent < 32);
            b32.in_sel   = 5'(sent);
            b32.in_tag   = 8'(sent);
            cycle32(a);
            if (a) sent++;
        end
        b32.in_valid = 1'b0;
        chk("sweep_count", 64'(delivered), 64'd32);
        chk("sweep_first_latency", 64'(first_lat), 64'd5);
        chk("sweep_no_gaps", 64'(last_del_cyc - first_del_cyc), 64'd31);

        // Backpressure: sel 3,7,11,... with out_ready 1-on/2-off.
        delivered = 0;
        sent = 0;
        saw_full = 0;
        for (int c = 0; c < 300 && delivered < 24; c++) begin
            b32.out_ready = (c % 3 == 0);
            b32.in_valid  = (sent < 24);
            b32.in_sel    = 5'((3 + 4 * sent) % 32);
            b32.in_tag    = 8'(8'h80 + sent);
            cycle32(a);
            if (a) sent++;
        end
        chk("bp_count", 64'(delivered), 64'd24);
        chk("bp_saw_full", 64'(saw_full > 0), 64'd1);
        drain32();

        // flush with three requests in flight and a colliding request.
        b32.out_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            b32.in_valid = 1'b1;
            b32.in_sel   = 5'(20 + r);
            b32.in_tag   = 8'(20 + r);
            cycle32(a);
        end
        flush32      = 1'b1;
        b32.in_valid = 1'b1;
        b32.in_sel   = 5'd9;
        b32.in_tag   = 8'd9;
        cycle32(a);
        flush32      = 1'b0;
        b32.in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cycle32(a);
            chk("flush_quiet", b32.out_valid, 1'b0);
        end
        delivered = 0;
        b32.in_valid = 1'b1;
        b32.in_sel   = 5'd10;
        b32.in_tag   = 8'd10;
        cycle32(a);
        b32.in_valid = 1'b0;
        for (int c = 0; c < 20 && delivered < 1; c++) cycle32(a);
        chk("flush_next_count", 64'(delivered), 64'd1);
        chk("flush_next_latency", 64'(first_lat), 64'd5);

        // Reset mid-stream with four requests compressed into the tail.
        b32.out_ready = 1'b0;
        for (int r = 0; r < 4; r++) begin
            b32.in_valid = 1'b1;
            b32.in_sel   = 5'(17 + r);
            b32.in_tag   = 8'(8'h40 + r);
            cycle32(a);
        end
        b32.in_valid = 1'b0;
        for (int c = 0; c < 4; c++) cycle32(a);
        chk("pre_reset_valid", b32.out_valid, 1'b1);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", b32.out_valid, 1'b0);
        chk("mid_rst_out_data", b32.out_data, 64'd0);
        chk("mid_rst_out_tag", b32.out_tag, 8'd0);
        chk("mid_rst_in_ready", b32.in_ready, 1'b1);
        #2 reset = 1'b0;
        q32.delete();
        occ32 = 0;
        prev_stall = 1'b0;
        step();
        b32.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cycle32(a);
            chk("post_rst_quiet", b32.out_valid, 1'b0);
        end
        delivered = 0;
        b32.in_valid = 1'b1;
        b32.in_sel   = 5'd31;
        b32.in_tag   = 8'h31;
        cycle32(a);
        b32.in_valid = 1'b0;
        for (int c = 0; c < 20 && delivered < 1; c++) cycle32(a);
        chk("post_rst_latency", 64'(first_lat), 64'd5);

        // Randomized traffic against the queue model.
        delivered = 0;
        sent = 0;
        for (int c = 0; c < 400; c++) begin
            b32.in_valid  = ($urandom_range(0, 3) != 0);
            b32.out_ready = ($urandom_range(0, 2) != 0);
            for (int w = 0; w < 64; w++) b32.in_data[w*32 +: 32] = $urandom();
            b32.in_sel = 5'($urandom_range(0, 31));
            b32.in_tag = 8'($urandom_range(0, 255));
            cycle32(a);
            if (a) sent++;
        end
        drain32();
        chk("rand_all_delivered", 64'(delivered), 64'(sent));

        // 5:1 instance: missing leaves and out-of-range selects, latency 3.
        b5.in_data    = {16'h1104, 16'h1103, 16'h1102, 16'h1101, 16'h1100};
        b5.out_ready  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b5.in_valid = 1'b1;
            b5.in_sel   = t5[i].sel;
            b5.in_tag   = 8'(8'h50 + i);
            chk("n5_in_ready", b5.in_ready, 1'b1);
            step();
            b5.in_valid = 1'b0;
            step();
            chk("n5_not_early", b5.out_valid, 1'b0);
            step();
            chk("n5_out_valid", b5.out_valid, 1'b1);
            chk("n5_out_data", b5.out_data, t5[i].data);
            chk("n5_out_err", b5.out_err, t5[i].err);
            chk("n5_out_tag", b5.out_tag, 8'(8'h50 + i));
        end
        step();

        // 2:1, 1-bit instance: all eight combinations back-to-back.
        b2.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b2.in_valid = 1'b1;
            b2.in_sel   = t2[i].sel;
            b2.in_data  = {t2[i].d1, t2[i].d0};
            b2.in_tag   = 8'(i);
            step();
            chk("n2_out_valid", b2.out_valid, 1'b1);
            chk("n2_out_data", b2.out_data, t2[i].exp);
            chk("n2_out_tag", b2.out_tag, 8'(i));
        end
        b2.in_valid = 1'b0;
        step();
        chk("n2_idle", b2.out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mux_tree_pipe.md
Name: mux_tree_pipe

Overview:
- Parametrised WIDTH-bit, NUM_IN:1 multiplexer built as a binary tree of 2:1 selection levels, with a pipeline register after every level.
- Each pipeline stage carries a valid bit and uses valid/ready flow control, so downstream logic can stall the tree without losing or duplicating data.
- Serves as the register-file read-port selector in multi-cycle and pipelined datapaths.
- Generalises the single-bit 2:1 mux in width, input count and timing.

Parameters:
- WIDTH, 64, data bits per input word.
- NUM_IN, 32, number of selectable inputs; legal range 2..256; need not be a power of 2.
- LEVELS, $clog2(NUM_IN), derived and not overridable; equals the number of tree levels and pipeline stages.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous; invalidates all stages on the next edge.
- in_valid  input  1  request present.
- in_ready  output  1  request accepted this cycle when in_valid && in_ready.
- in_data  input  NUM_IN*WIDTH  flattened inputs; word k = in_data[k*WIDTH +: WIDTH].
- in_sel  input  LEVELS  index of the selected word.
- in_tag  input  8  opaque tag, carried unchanged alongside the data.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts this cycle.
- out_data  output  WIDTH  selected word.
- out_tag  output  8  tag of that request.
- out_err  output  1  set when in_sel >= NUM_IN.

Behaviour:
- Reset (asynchronous assert and deassert):
  - All stage valid bits, data, tag and err registers clear to 0.
  - Outputs are therefore out_valid=0, out_data=0, out_tag=0, out_err=0.
  - in_ready=1 immediately, because the pipe is empty.
- Tree structure:
  - Level j (j = 0..LEVELS-1) uses select bit sel[j] to pair adjacent candidates: candidate 2m is chosen when the bit is 0, 2m+1 when it is 1.
  - Stage j registers the surviving candidates (ceil(NUM_IN / 2^(j+1)) words), the remaining select bits sel[LEVELS-1:j+1], the tag, the err flag and valid.
- Missing leaves: when NUM_IN is not a power of 2, leaves NUM_IN..2^LEVELS-1 read as 0. If in_sel >= NUM_IN, then out_data=0 and out_err=1. The request still completes normally.
- Latency: LEVELS cycles from acceptance to out_valid when the pipe is not stalled. NUM_IN=32 gives 5 cycles; NUM_IN=2 gives 1 cycle.
- Throughput: one request per cycle when out_ready is held at 1.
- Flow control:
  - Stage j loads when stage j is empty OR stage j+1 loads; for the last stage, read "stage j+1 loads" as out_ready.
  - in_ready = stage-0 load condition (combinational).
  - out_valid = last stage valid.
  - Stalled stages hold data, tag and err stable.
  - Bubbles collapse: an empty stage accepts even while downstream is stalled.
- Output stability: while out_valid=1 and out_ready=0, out_data, out_tag and out_err must not change.
- in_sel, in_tag and in_data are sampled only on acceptance; changes on non-accepting cycles have no effect.
- flush:
  - On the next edge all valid bits go to 0; data registers may keep stale values.
  - flush overrides any acceptance in that cycle, so the request is dropped.
  - in_ready is still computed normally during the flush cycle.
- Reset mid-operation: all in-flight requests are discarded and no partial output appears. After deassert, the block behaves exactly as after power-on.
- Simultaneous out_ready and in_valid with a full pipe: one request leaves and one enters on the same edge, and occupancy stays at LEVELS.

Test Plan:
- Ordering sweep:
  - Stimulus: WIDTH=64, NUM_IN=32, in_data word k = 64'hA5A5_0000_0000_0000 + k, out_ready=1; issue in_sel 0..31 back-to-back with in_tag = sel.
  - Response: first out_valid 5 cycles after the first acceptance; then 32 consecutive results, word sel with tag sel, in order and without gaps.
- Backpressure:
  - Stimulus: stream sel 3,7,11,... with out_ready toggled on a 1-on/2-off pattern.
  - Response: no loss or duplication; outputs held while stalled; once the pipe fills, in_ready=0 exactly when the last stage is full and out_ready=0.
- Non-power-of-2 size:
  - Stimulus: NUM_IN=5; in_sel=4, then 5, then 7.
  - Response: word 4 with out_err=0; then 0 with out_err=1, twice; latency 3.
- flush:
  - Stimulus: after 3 accepted requests, assert flush for one cycle together with in_valid=1 (sel=9).
  - Response: out_valid stays 0 for the following 5 cycles; sel=9 is never output; the next request completes in 5 cycles.
- Reset mid-stream:
  - Stimulus: with 4 requests in flight, pulse reset asynchronously between edges.
  - Response: out_valid, out_data and out_tag go to 0 immediately; in_ready=1; no stale result after deassert.
- Minimum size:
  - Stimulus: NUM_IN=2, WIDTH=1; exercise all 8 combinations of in_sel and the two data bits, with out_ready=1.
  - Response: out_data = sel ? in_data[1] : in_data[0], with 1-cycle latency.
